// File: rtl/seq_tx_pkg.sv
// seq_tx_pkg: shared types and constants for the serial pattern transmitter.
// The PAR state is present only when SEQ_TX_PARITY_EN is defined.
package seq_tx_pkg;
    typedef enum logic [2:0] {
        IDLE,
        SEND,
`ifdef SEQ_TX_PARITY_EN
        PAR,
`endif
        GAP,
        DONE
    } state_t;
    localparam logic IDLE_LVL = 1'b1;
    localparam logic [6:0] DEF_PATTERN = 7'b0101010;
endpackage

// File: rtl/seq_tx_shift.sv
// seq_tx_shift: pattern register, bit counter and MSB-first shifter for seq_tx.
// Even-parity output exists only when SEQ_TX_PARITY_EN is defined.
module seq_tx_shift #(
    parameter int PAT_W = 7,
    parameter logic [PAT_W-1:0] PATTERN = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             adv,
    output logic             msb,
    output logic             bit_nxt,
    output logic             last
`ifdef SEQ_TX_PARITY_EN
    ,
    output logic             par
`endif
);
    logic [PAT_W-1:0] pat;
    logic [PAT_W-1:0] sh;
    logic [3:0] cnt;
    logic step;

    assign step = adv && !last;
    assign msb = pat[PAT_W-1];
    assign bit_nxt = sh[PAT_W-2];
    assign last = cnt == 4'(PAT_W - 1);
`ifdef SEQ_TX_PARITY_EN
    assign par = ^pat;
`endif

    // sh mirrors pat outside SEND so the bit after the MSB is always ready
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pat <= PATTERN;
            sh  <= PATTERN;
            cnt <= '0;
        end else begin
            pat <= ld ? pat_in : pat;
            sh  <= step ? {sh[PAT_W-2:0], 1'b0} : (ld ? pat_in : pat);
            cnt <= step ? cnt + 4'd1 : 4'd0;
        end
endmodule

// File: rtl/seq_tx.sv
// seq_tx: repeating serial pattern transmitter with gap cycles and done pulse.
// Define SEQ_TX_PARITY_EN to append an even-parity bit to every repetition.
module seq_tx
    import seq_tx_pkg::*;
#(
    parameter int PAT_W = 7,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int GAP_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [3:0]       reps,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);
    state_t state;
    logic [3:0] rep_cnt;
    logic [3:0] gap_cnt;
    logic msb, bit_nxt, last, eop, more;
`ifdef SEQ_TX_PARITY_EN
    logic par;
`endif

    seq_tx_shift #(.PAT_W(PAT_W), .PATTERN(PATTERN)) u_shift (
        .clk     (clk),
        .rst     (rst),
        .ld      (state == IDLE && load),
        .pat_in  (pat_in),
        .adv     (state == SEND),
        .msb     (msb),
        .bit_nxt (bit_nxt),
        .last    (last)
`ifdef SEQ_TX_PARITY_EN
        ,
        .par     (par)
`endif
    );

    // rep_cnt is decremented on the last pattern bit, so PAR sees the reduced value
`ifdef SEQ_TX_PARITY_EN
    assign eop = state == PAR;
    assign more = rep_cnt != 4'd0;
`else
    assign eop = state == SEND && last;
    assign more = rep_cnt != 4'd1;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            dout       <= IDLE_LVL;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rep_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state      <= SEND;
                    busy       <= 1'b1;
                    dout       <= load ? pat_in[PAT_W-1] : msb;
                    dout_valid <= 1'b1;
                    rep_cnt    <= reps == 4'd0 ? 4'd1 : reps;
                end
                SEND: if (!last) dout <= bit_nxt;
                else begin
                    rep_cnt <= rep_cnt != 4'd0 ? rep_cnt - 4'd1 : 4'd0;
`ifdef SEQ_TX_PARITY_EN
                    state <= PAR;
                    dout  <= par;
`endif
                end
                GAP: if (gap_cnt == 4'd0) begin
                    state      <= SEND;
                    dout       <= msb;
                    dout_valid <= 1'b1;
                end else gap_cnt <= gap_cnt - 4'd1;
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= state;
            endcase
            if (eop) begin
                if (!more) begin
                    state      <= DONE;
                    dout       <= IDLE_LVL;
                    dout_valid <= 1'b0;
                    done       <= 1'b1;
                end else if (GAP_CYC == 0) begin
                    state      <= SEND;
                    dout       <= msb;
                    dout_valid <= 1'b1;
                end else begin
                    state      <= GAP;
                    dout       <= IDLE_LVL;
                    dout_valid <= 1'b0;
                    gap_cnt    <= 4'(GAP_CYC - 1);
                end
            end
        end
endmodule

// File: tb/tb_seq_tx.sv
// tb_seq_tx: directed self-checking bench for seq_tx (u0: GAP_CYC=1, u1: GAP_CYC=0).
// With SEQ_TX_PARITY_EN defined only the reset and parity scenarios run.
module tb_seq_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0, load0 = 1'b0, load1 = 1'b0;
    logic [6:0] pat_in = '0;
    logic [3:0] reps = '0;
    logic dout0, dout_valid0, busy0, done0;
    logic dout1, dout_valid1, busy1, done1;
    logic [255:0] dtr, vtr, vb, expv;
    logic [9:0] bk, vk, dk;
    int nval, ncyc, nbusy, ndone;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    seq_tx #(.GAP_CYC(1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .load(load0), .pat_in(pat_in), .reps(reps),
        .dout(dout0), .dout_valid(dout_valid0), .busy(busy0), .done(done0)
    );

    seq_tx #(.GAP_CYC(0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .load(load1), .pat_in(pat_in), .reps(reps),
        .dout(dout1), .dout_valid(dout_valid1), .busy(busy1), .done(done1)
    );

    task automatic burst(input bit sel, input logic ld, input logic [6:0] p, input logic [3:0] r,
                         input int ld_at, input int max);
        logic d, v;
        if (sel) begin start1 = 1'b1; load1 = ld; end
        else begin start0 = 1'b1; load0 = ld; end
        pat_in = p;
        reps = r;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; load0 = 1'b0; load1 = 1'b0;
        dtr = '0; vtr = '0; vb = '0; nval = 0; ncyc = 0; nbusy = 0; ndone = 0;
        while (1) begin
            d = sel ? dout1 : dout0;
            v = sel ? dout_valid1 : dout_valid0;
            dtr = {dtr[254:0], d};
            vtr = {vtr[254:0], v};
            if (v) begin vb = {vb[254:0], d}; nval++; end
            if (sel ? busy1 : busy0) nbusy++;
            if (sel ? done1 : done0) ndone++;
            ncyc++;
            if (ndone != 0 || ncyc >= max) break;
            if (!sel && ncyc == ld_at) begin load0 = 1'b1; pat_in = 7'b0000001; end
            else load0 = 1'b0;
            @(negedge clk);
            load0 = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++; if ({dout0, dout_valid0, busy0, done0} !== 4'b1000) begin errors++; $display("FAIL reset_u0 got %b exp 1000", {dout0, dout_valid0, busy0, done0}); end
        checks++; if ({dout1, dout_valid1, busy1, done1} !== 4'b1000) begin errors++; $display("FAIL reset_u1 got %b exp 1000", {dout1, dout_valid1, busy1, done1}); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({dout0, dout_valid0, busy0, done0} !== 4'b1000) begin errors++; $display("FAIL idle_after_reset got %b exp 1000", {dout0, dout_valid0, busy0, done0}); end
    endtask

    task automatic test_basic;
        burst(0, 1'b0, 7'b0, 4'd1, -1, 40);
        checks++; if (ndone !== 1) begin errors++; $display("FAIL basic_done got %0d exp 1", ndone); end
        checks++; if (ncyc !== 8) begin errors++; $display("FAIL basic_len got %0d exp 8", ncyc); end
        checks++; if (nval !== 7) begin errors++; $display("FAIL basic_nval got %0d exp 7", nval); end
        checks++; if (vb[6:0] !== 7'b0101010) begin errors++; $display("FAIL basic_bits got %b exp 0101010", vb[6:0]); end
        checks++; if (vtr[7:0] !== 8'b11111110) begin errors++; $display("FAIL basic_valid got %b exp 11111110", vtr[7:0]); end
        checks++; if (nbusy !== 8) begin errors++; $display("FAIL basic_busy got %0d exp 8", nbusy); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy0); end
    endtask

    task automatic test_load_gap;
        load0 = 1'b1; pat_in = 7'b1100101;
        @(negedge clk);
        load0 = 1'b0;
        burst(0, 1'b0, 7'b0, 4'd2, -1, 60);
        checks++; if (ncyc !== 16) begin errors++; $display("FAIL gap_len got %0d exp 16", ncyc); end
        checks++; if (dtr[15:0] !== 16'b1100101_1_1100101_1) begin errors++; $display("FAIL gap_dout got %b exp 1100101111001011", dtr[15:0]); end
        checks++; if (vtr[15:0] !== 16'b1111111_0_1111111_0) begin errors++; $display("FAIL gap_valid got %b exp 1111111011111110", vtr[15:0]); end
    endtask

    task automatic test_load_start;
        burst(0, 1'b1, 7'b1111000, 4'd1, 3, 40);
        checks++; if (ncyc !== 8) begin errors++; $display("FAIL ldst_len got %0d exp 8", ncyc); end
        checks++; if (dtr[7:0] !== 8'b11110001) begin errors++; $display("FAIL ldst_dout got %b exp 11110001", dtr[7:0]); end
        burst(0, 1'b0, 7'b0, 4'd1, -1, 40);
        checks++; if (dtr[7:0] !== 8'b11110001) begin errors++; $display("FAIL busy_load_ignored got %b exp 11110001", dtr[7:0]); end
    endtask

    task automatic test_reps;
        burst(0, 1'b0, 7'b0, 4'd0, -1, 40);
        checks++; if (nval !== 7) begin errors++; $display("FAIL reps0_nval got %0d exp 7", nval); end
        checks++; if (ncyc !== 8) begin errors++; $display("FAIL reps0_len got %0d exp 8", ncyc); end
        burst(1, 1'b0, 7'b0, 4'd15, -1, 200);
        expv = ((256'd1 << 105) - 256'd1) << 1;
        checks++; if (ndone !== 1) begin errors++; $display("FAIL reps15_done got %0d exp 1", ndone); end
        checks++; if (nval !== 105) begin errors++; $display("FAIL reps15_nval got %0d exp 105", nval); end
        checks++; if (ncyc !== 106) begin errors++; $display("FAIL reps15_len got %0d exp 106", ncyc); end
        checks++; if (vtr[105:0] !== expv[105:0]) begin errors++; $display("FAIL reps15_valid got %h exp %h", vtr[105:0], expv[105:0]); end
        checks++; if (vb[104:0] !== {15{7'b0101010}}) begin errors++; $display("FAIL reps15_bits got %h exp %h", vb[104:0], {15{7'b0101010}}); end
    endtask

    task automatic test_start_held;
        int k;
        start0 = 1'b1; reps = 4'd1;
        bk = '0; vk = '0; dk = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bk = {bk[8:0], busy0};
            vk = {vk[8:0], dout_valid0};
            dk = {dk[8:0], done0};
        end
        start0 = 1'b0;
        checks++; if (bk !== 10'b1111111101) begin errors++; $display("FAIL held_busy got %b exp 1111111101", bk); end
        checks++; if (vk !== 10'b1111111001) begin errors++; $display("FAIL held_valid got %b exp 1111111001", vk); end
        checks++; if (dk !== 10'b0000000100) begin errors++; $display("FAIL held_done got %b exp 0000000100", dk); end
        k = 0;
        while (done0 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL held_drain got %b exp 1", done0); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        start0 = 1'b1; reps = 4'd3;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dout_valid0 !== 1'b1) begin errors++; $display("FAIL mid_precond got %b exp 1", dout_valid0); end
        rst = 1'b1;
        #1;
        checks++; if ({dout0, dout_valid0, busy0, done0} !== 4'b1000) begin errors++; $display("FAIL mid_abort got %b exp 1000", {dout0, dout_valid0, busy0, done0}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({dout0, dout_valid0, busy0, done0} !== 4'b1000) begin errors++; $display("FAIL mid_after got %b exp 1000", {dout0, dout_valid0, busy0, done0}); end
        burst(0, 1'b0, 7'b0, 4'd1, -1, 40);
        checks++; if (ncyc !== 8) begin errors++; $display("FAIL mid_restart_len got %0d exp 8", ncyc); end
        checks++; if (dtr[7:0] !== 8'b01010101) begin errors++; $display("FAIL mid_restart_dout got %b exp 01010101", dtr[7:0]); end
    endtask

    task automatic test_parity;
        burst(0, 1'b0, 7'b0, 4'd1, -1, 40);
        checks++; if (nval !== 8) begin errors++; $display("FAIL par_nval got %0d exp 8", nval); end
        checks++; if (vb[7:0] !== 8'b01010101) begin errors++; $display("FAIL par_bits_def got %b exp 01010101", vb[7:0]); end
        burst(0, 1'b1, 7'b1100110, 4'd1, -1, 40);
        checks++; if (vb[7:0] !== 8'b11001100) begin errors++; $display("FAIL par_bits_ld got %b exp 11001100", vb[7:0]); end
        burst(1, 1'b0, 7'b0, 4'd2, -1, 40);
        checks++; if (vb[15:0] !== 16'b01010101_01010101) begin errors++; $display("FAIL par_b2b got %b exp 0101010101010101", vb[15:0]); end
        checks++; if (ncyc !== 17) begin errors++; $display("FAIL par_b2b_len got %0d exp 17", ncyc); end
    endtask

    initial begin
        test_reset;
`ifdef SEQ_TX_PARITY_EN
        test_parity;
`else
        test_basic;
        test_load_gap;
        test_load_start;
        test_reps;
        test_start_held;
        test_reset_mid;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
